// File: rtl/game_input_ctrl_if.sv
// Signal bundle between the pushbutton/joystick sources and game_input_ctrl.
// The master side (board wiring or bench) drives the raw inputs and game status;
// the slave side (game_input_ctrl) returns the registered direction.
//
// Handshake: dir_valid is a one-cycle strobe with no back-pressure (no ready).
// The consumer must take dir_out in the cycle dir_valid is high. dir_out keeps
// its value until the next strobe, or until game-over clears it to 0000.
// fsm_state exposes the controller state (0 IDLE, 1 RUN, 2 PAUSE, 3 OVER).
interface game_input_ctrl_if;
  logic       BTNU;
  logic       BTND;
  logic       BTNL;
  logic       BTNR;
  logic [3:0] spi_x_out;
  logic [3:0] spi_y_out;
  logic       frz;
  logic       over;
  logic [3:0] dir_out;
  logic       dir_valid;
  logic       src_joy;
  logic [1:0] fsm_state;

  modport master (
    output BTNU, BTND, BTNL, BTNR, spi_x_out, spi_y_out, frz, over,
    input  dir_out, dir_valid, src_joy, fsm_state
  );

  modport slave (
    input  BTNU, BTND, BTNL, BTNR, spi_x_out, spi_y_out, frz, over,
    output dir_out, dir_valid, src_joy, fsm_state
  );
endinterface

// File: rtl/game_input_ctrl.sv
// game_input_ctrl: direction front-end for the vga game core.
// Debounces the four pushbuttons, optionally decodes the joystick, arbitrates
// into one registered one-hot direction {up,down,left,right} and filters
// reversals, freeze and game-over.
// Optional feature: define GAME_INPUT_JOY_EN to build the joystick path.
// Without it spi_x_out/spi_y_out are unused and src_joy stays 0.
module game_input_ctrl #(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int JOY_CENTER = 8,
  parameter int JOY_DEAD   = 3
) (
  input logic             clk,
  input logic             I_rst_n,
  game_input_ctrl_if.slave io
);

  localparam int CW = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

  // Button order everywhere below: [3]=U, [2]=D, [1]=L, [0]=R
  logic [3:0]    raw_btn;
  logic [3:0]    sync1, sync2;
  logic [3:0]    db_lvl, db_d, press_q;
  logic [CW-1:0] cnt [4];

  logic          joy_ev_q;
  logic [3:0]    joy_dir_q;

  logic [3:0]    ev_dir;
  logic          ev_valid;
  logic          ev_src;
  logic [3:0]    rev_dir;

  state_t        state;
  logic [3:0]    dir_q;
  logic          valid_q;
  logic          src_q;

  assign raw_btn = {io.BTNU, io.BTND, io.BTNL, io.BTNR};

  // Two-flop synchroniser for the asynchronous pushbuttons
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

  // Debounce: the synced level must disagree for DB_CYCLES edges before it is accepted
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      db_lvl <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          db_lvl[i] <= ~db_lvl[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press events are registered rising edges of the debounced level
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      db_d    <= '0;
      press_q <= '0;
    end else begin
      db_d    <= db_lvl;
      press_q <= db_lvl & ~db_d;
    end
  end

`ifdef GAME_INPUT_JOY_EN
  // Axis offsets are 5-bit two's complement; magnitudes are taken unsigned
  logic [4:0] dx, dy, adx, ady;
  logic       joy_defl, joy_defl_d;
  logic [3:0] joy_dir, joy_dir_d;

  assign dx       = 5'({1'b0, io.spi_x_out}) - 5'(JOY_CENTER);
  assign dy       = 5'({1'b0, io.spi_y_out}) - 5'(JOY_CENTER);
  assign adx      = dx[4] ? (~dx + 5'd1) : dx;
  assign ady      = dy[4] ? (~dy + 5'd1) : dy;
  assign joy_defl = (adx > 5'(JOY_DEAD)) || (ady > 5'(JOY_DEAD));

  // Dominant axis picks the direction; equal magnitudes resolve to horizontal
  always_comb begin
    joy_dir = 4'b0000;
    if (joy_defl) begin
      if (adx >= ady) joy_dir = dx[4] ? 4'b0010 : 4'b0001;
      else            joy_dir = dy[4] ? 4'b0100 : 4'b1000;
    end
  end

  // Joystick event on the first deflected cycle or on a direction change
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      joy_defl_d <= 1'b0;
      joy_dir_d  <= '0;
      joy_ev_q   <= 1'b0;
      joy_dir_q  <= '0;
    end else begin
      joy_defl_d <= joy_defl;
      joy_dir_d  <= joy_dir;
      joy_ev_q   <= joy_defl && (!joy_defl_d || (joy_dir != joy_dir_d));
      joy_dir_q  <= joy_dir;
    end
  end
`else
  assign joy_ev_q  = 1'b0;
  assign joy_dir_q = 4'b0000;
`endif

  // Arbitration: any button beats the joystick; buttons ranked U > D > L > R
  always_comb begin
    ev_dir   = 4'b0000;
    ev_valid = 1'b0;
    ev_src   = 1'b0;
    if (press_q[3]) begin
      ev_dir = 4'b1000; ev_valid = 1'b1;
    end else if (press_q[2]) begin
      ev_dir = 4'b0100; ev_valid = 1'b1;
    end else if (press_q[1]) begin
      ev_dir = 4'b0010; ev_valid = 1'b1;
    end else if (press_q[0]) begin
      ev_dir = 4'b0001; ev_valid = 1'b1;
    end else if (joy_ev_q) begin
      ev_dir = joy_dir_q; ev_valid = 1'b1; ev_src = 1'b1;
    end
  end

  // Opposite of the current direction (U<->D, L<->R)
  assign rev_dir = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};

  // Game-state FSM; all outputs registered here
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= IDLE;
      dir_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.over) begin
            state <= OVER;
            dir_q <= '0;
          end else if (ev_valid) begin
            state   <= RUN;
            dir_q   <= ev_dir;
            valid_q <= 1'b1;
            src_q   <= ev_src;
          end
        end
        RUN: begin
          if (io.over) begin
            state <= OVER;
            dir_q <= '0;
          end else if (io.frz) begin
            state <= PAUSE;
          end else if (ev_valid && (ev_dir != dir_q) && (ev_dir != rev_dir)) begin
            dir_q   <= ev_dir;
            valid_q <= 1'b1;
            src_q   <= ev_src;
          end
        end
        PAUSE: begin
          if (io.over) begin
            state <= OVER;
            dir_q <= '0;
          end else if (!io.frz) begin
            state <= RUN;
          end
        end
        OVER: begin
          dir_q <= '0;
          if (!io.over) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          dir_q <= '0;
        end
      endcase
    end
  end

  assign io.dir_out   = dir_q;
  assign io.dir_valid = valid_q;
  assign io.src_joy   = src_q;
  assign io.fsm_state = state;

endmodule
